// File: rtl/mod_148_4_4_timers_pkg.sv
// Shared definitions for the PLCA timer bank: timer state encoding and
// default durations (in bit times) of the fixed-length timers.
package mod_148_4_4_timers_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StRun     = 2'b01,
    StExpired = 2'b10
  } timer_state_e;

  localparam int unsigned BeaconBtDefault        = 20;
  localparam int unsigned BeaconDetBtDefault     = 22;
  localparam int unsigned InvalidBeaconBtDefault = 4000;
  localparam int unsigned IbtWDefault            = 12;

endpackage

// File: rtl/plca_timer_unit.sv
// One PLCA bit-time timer: IDLE / RUN / EXPIRED with a down-counter that
// decrements on bit_tick while running. stop has priority over start.
module plca_timer_unit
  import mod_148_4_4_timers_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         plca_reset,
  input  logic         bit_tick,
  input  logic         start,
  input  logic         stop,
  input  logic [W-1:0] dur,
  output logic         done,
  output logic         not_done,
  output logic [W-1:0] count
);

  timer_state_e state_q;
  logic [W-1:0] cnt_q;

  // State and counter update; a zero duration still needs one counted tick.
  always_ff @(posedge clk) begin
    if (plca_reset || stop) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else if (start) begin
      state_q <= StRun;
      cnt_q   <= (dur == '0) ? W'(1) : dur;
    end else if (state_q == StRun && bit_tick) begin
      if (cnt_q <= W'(1)) begin
        state_q <= StExpired;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  assign done     = (state_q == StExpired);
  assign not_done = (state_q == StRun);
  assign count    = cnt_q;

endmodule

// File: rtl/mod_148_4_4_timers.sv
// PLCA timer bank: to_timer, beacon_timer, beacon_det_timer,
// invalid_beacon_timer and burst_timer, all counted in bit times.
// Define PLCA_TIMER_DEBUG_EN to expose the live to/burst timer counters.
module mod_148_4_4_timers
  import mod_148_4_4_timers_pkg::*;
#(
  parameter int unsigned BEACON_BT         = BeaconBtDefault,
  parameter int unsigned BEACON_DET_BT     = BeaconDetBtDefault,
  parameter int unsigned INVALID_BEACON_BT = InvalidBeaconBtDefault,
  parameter int unsigned IBT_W             = IbtWDefault
) (
  input  logic       clk,
  input  logic       plca_reset,
  input  logic       bit_tick,
  input  logic       all_timers_stop,
  input  logic [7:0] plca_to_timer,
  input  logic [7:0] plca_burst_timer,
  input  logic       to_timer_start,
  input  logic       to_timer_stop,
  input  logic       beacon_timer_start,
  input  logic       beacon_det_timer_start,
  input  logic       invalid_beacon_timer_start,
  input  logic       burst_timer_start,
  output logic       to_timer_done,
  output logic       to_timer_not_done,
  output logic       beacon_timer_done,
  output logic       beacon_det_timer_done,
  output logic       beacon_det_timer_not_done,
  output logic       invalid_beacon_timer_done,
  output logic       burst_timer_done
`ifdef PLCA_TIMER_DEBUG_EN
  ,
  output logic [7:0] to_timer_count,
  output logic [7:0] burst_timer_count
`endif
);

  localparam int unsigned BeaconW    = $clog2(BEACON_BT + 1);
  localparam int unsigned BeaconDetW = $clog2(BEACON_DET_BT + 1);

  logic                  to_stop;
  logic [7:0]            to_cnt;
  logic [7:0]            burst_cnt;
  logic [BeaconW-1:0]    beacon_cnt;
  logic [BeaconDetW-1:0] beacon_det_cnt;
  logic [IBT_W-1:0]      invalid_beacon_cnt;
  logic                  beacon_nd;
  logic                  invalid_beacon_nd;
  logic                  burst_nd;
  logic                  unused_signals;

  // A start alongside to_timer_stop restarts; all_timers_stop always wins.
  assign to_stop = all_timers_stop | (to_timer_stop & ~to_timer_start);

  plca_timer_unit #(.W(8)) u_to_timer (
    .clk       (clk),
    .plca_reset(plca_reset),
    .bit_tick  (bit_tick),
    .start     (to_timer_start),
    .stop      (to_stop),
    .dur       (plca_to_timer),
    .done      (to_timer_done),
    .not_done  (to_timer_not_done),
    .count     (to_cnt)
  );

  plca_timer_unit #(.W(BeaconW)) u_beacon_timer (
    .clk       (clk),
    .plca_reset(plca_reset),
    .bit_tick  (bit_tick),
    .start     (beacon_timer_start),
    .stop      (all_timers_stop),
    .dur       (BeaconW'(BEACON_BT)),
    .done      (beacon_timer_done),
    .not_done  (beacon_nd),
    .count     (beacon_cnt)
  );

  plca_timer_unit #(.W(BeaconDetW)) u_beacon_det_timer (
    .clk       (clk),
    .plca_reset(plca_reset),
    .bit_tick  (bit_tick),
    .start     (beacon_det_timer_start),
    .stop      (all_timers_stop),
    .dur       (BeaconDetW'(BEACON_DET_BT)),
    .done      (beacon_det_timer_done),
    .not_done  (beacon_det_timer_not_done),
    .count     (beacon_det_cnt)
  );

  plca_timer_unit #(.W(IBT_W)) u_invalid_beacon_timer (
    .clk       (clk),
    .plca_reset(plca_reset),
    .bit_tick  (bit_tick),
    .start     (invalid_beacon_timer_start),
    .stop      (all_timers_stop),
    .dur       (IBT_W'(INVALID_BEACON_BT)),
    .done      (invalid_beacon_timer_done),
    .not_done  (invalid_beacon_nd),
    .count     (invalid_beacon_cnt)
  );

  plca_timer_unit #(.W(8)) u_burst_timer (
    .clk       (clk),
    .plca_reset(plca_reset),
    .bit_tick  (bit_tick),
    .start     (burst_timer_start),
    .stop      (all_timers_stop),
    .dur       (plca_burst_timer),
    .done      (burst_timer_done),
    .not_done  (burst_nd),
    .count     (burst_cnt)
  );

`ifdef PLCA_TIMER_DEBUG_EN
  assign to_timer_count    = to_cnt;
  assign burst_timer_count = burst_cnt;
  assign unused_signals    = ^{beacon_cnt, beacon_det_cnt, invalid_beacon_cnt,
                               beacon_nd, invalid_beacon_nd, burst_nd};
`else
  assign unused_signals    = ^{to_cnt, burst_cnt, beacon_cnt, beacon_det_cnt,
                               invalid_beacon_cnt, beacon_nd, invalid_beacon_nd,
                               burst_nd};
`endif

endmodule

// File: tb/tb_mod_148_4_4_timers.sv
// Directed bench for the PLCA timer bank; bit_tick fires every 4th cycle.
module tb_mod_148_4_4_timers;

  logic       clk = 1'b0;
  logic       plca_reset, bit_tick, all_timers_stop;
  logic [7:0] plca_to_timer, plca_burst_timer;
  logic       to_timer_start, to_timer_stop, beacon_timer_start;
  logic       beacon_det_timer_start, invalid_beacon_timer_start, burst_timer_start;
  logic       to_timer_done, to_timer_not_done, beacon_timer_done;
  logic       beacon_det_timer_done, beacon_det_timer_not_done;
  logic       invalid_beacon_timer_done, burst_timer_done;
`ifdef PLCA_TIMER_DEBUG_EN
  logic [7:0] to_timer_count, burst_timer_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mod_148_4_4_timers dut (
    .clk                       (clk),
    .plca_reset                (plca_reset),
    .bit_tick                  (bit_tick),
    .all_timers_stop           (all_timers_stop),
    .plca_to_timer             (plca_to_timer),
    .plca_burst_timer          (plca_burst_timer),
    .to_timer_start            (to_timer_start),
    .to_timer_stop             (to_timer_stop),
    .beacon_timer_start        (beacon_timer_start),
    .beacon_det_timer_start    (beacon_det_timer_start),
    .invalid_beacon_timer_start(invalid_beacon_timer_start),
    .burst_timer_start         (burst_timer_start),
    .to_timer_done             (to_timer_done),
    .to_timer_not_done         (to_timer_not_done),
    .beacon_timer_done         (beacon_timer_done),
    .beacon_det_timer_done     (beacon_det_timer_done),
    .beacon_det_timer_not_done (beacon_det_timer_not_done),
    .invalid_beacon_timer_done (invalid_beacon_timer_done),
    .burst_timer_done          (burst_timer_done)
`ifdef PLCA_TIMER_DEBUG_EN
    ,
    .to_timer_count            (to_timer_count),
    .burst_timer_count         (burst_timer_count)
`endif
  );

  // {to_done, to_not_done, beacon_done, det_done, det_not_done, inv_done, burst_done}
  function automatic logic [6:0] outs();
    return {to_timer_done, to_timer_not_done, beacon_timer_done, beacon_det_timer_done,
            beacon_det_timer_not_done, invalid_beacon_timer_done, burst_timer_done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // n bit times: three quiet cycles then one tick cycle each.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bit_tick = 1'b0;
      repeat (3) clk1();
      bit_tick = 1'b1;
      clk1();
      bit_tick = 1'b0;
    end
  endtask

  initial begin
    plca_reset = 1'b1; bit_tick = 1'b0; all_timers_stop = 1'b0;
    plca_to_timer = 8'd32; plca_burst_timer = 8'd128;
    to_timer_start = 1'b0; to_timer_stop = 1'b0; beacon_timer_start = 1'b0;
    beacon_det_timer_start = 1'b0; invalid_beacon_timer_start = 1'b0;
    burst_timer_start = 1'b0;
    repeat (2) clk1();
    plca_reset = 1'b0;
    chk("reset_outs", 32'(outs()), 32'h0);

    // Reset in the middle of all five runs
    to_timer_start = 1'b1; beacon_timer_start = 1'b1; beacon_det_timer_start = 1'b1;
    invalid_beacon_timer_start = 1'b1; burst_timer_start = 1'b1;
    clk1();
    to_timer_start = 1'b0; beacon_timer_start = 1'b0; beacon_det_timer_start = 1'b0;
    invalid_beacon_timer_start = 1'b0; burst_timer_start = 1'b0;
    chk("all_running", 32'(outs()), 32'b0100100);
    tick_n(2);
    plca_reset = 1'b1;
    clk1();
    plca_reset = 1'b0;
    chk("reset_midrun", 32'(outs()), 32'h0);
    tick_n(25);
    chk("reset_holds", 32'(outs()), 32'h0);

    // to_timer: 32 ticks, not_done throughout
    to_timer_start = 1'b1;
    clk1();
    to_timer_start = 1'b0;
    chk("to_start", {30'h0, to_timer_done, to_timer_not_done}, 32'b01);
    for (int i = 1; i < 32; i++) begin
      tick_n(1);
      chk("to_running", {30'h0, to_timer_done, to_timer_not_done}, 32'b01);
    end
    tick_n(1);
    chk("to_expired", {30'h0, to_timer_done, to_timer_not_done}, 32'b10);
    tick_n(3);
    chk("to_held", {30'h0, to_timer_done, to_timer_not_done}, 32'b10);

    // Stop, then start+stop together restarts with a fresh 32
    to_timer_start = 1'b1;
    clk1();
    to_timer_start = 1'b0;
    tick_n(10);
    to_timer_stop = 1'b1;
    clk1();
    to_timer_stop = 1'b0;
    chk("to_stopped", {30'h0, to_timer_done, to_timer_not_done}, 32'b00);
    to_timer_start = 1'b1; to_timer_stop = 1'b1;
    clk1();
    to_timer_start = 1'b0; to_timer_stop = 1'b0;
    chk("to_start_stop", {30'h0, to_timer_done, to_timer_not_done}, 32'b01);
    tick_n(31);
    chk("to_fresh_31", {30'h0, to_timer_done, to_timer_not_done}, 32'b01);
    tick_n(1);
    chk("to_fresh_32", {30'h0, to_timer_done, to_timer_not_done}, 32'b10);

    // burst_timer: restart on the expiring tick
    burst_timer_start = 1'b1;
    clk1();
    burst_timer_start = 1'b0;
    tick_n(127);
    chk("burst_127", 32'(burst_timer_done), 32'h0);
    repeat (3) clk1();
    bit_tick = 1'b1; burst_timer_start = 1'b1;
    clk1();
    bit_tick = 1'b0; burst_timer_start = 1'b0;
    chk("burst_restart", 32'(burst_timer_done), 32'h0);
    tick_n(127);
    chk("burst_r127", 32'(burst_timer_done), 32'h0);
    tick_n(1);
    chk("burst_r128", 32'(burst_timer_done), 32'h1);
    // Zero duration acts as one; tick alongside start is not counted
    plca_burst_timer = 8'd0;
    bit_tick = 1'b1; burst_timer_start = 1'b1;
    clk1();
    bit_tick = 1'b0; burst_timer_start = 1'b0;
    chk("burst0_start", 32'(burst_timer_done), 32'h0);
    tick_n(1);
    chk("burst0_done", 32'(burst_timer_done), 32'h1);

    // invalid_beacon_timer with a mid-run plca_to_timer change
    invalid_beacon_timer_start = 1'b1; to_timer_start = 1'b1;
    clk1();
    invalid_beacon_timer_start = 1'b0; to_timer_start = 1'b0;
    tick_n(5);
    plca_to_timer = 8'd8;
    tick_n(3);
    chk("to_unaffected_8", {30'h0, to_timer_done, to_timer_not_done}, 32'b01);
    tick_n(23);
    chk("to_unaffected_31", {30'h0, to_timer_done, to_timer_not_done}, 32'b01);
    tick_n(1);
    chk("to_unaffected_32", {30'h0, to_timer_done, to_timer_not_done}, 32'b10);
    plca_to_timer = 8'd32;
    tick_n(3967);
    chk("ibt_3999", 32'(invalid_beacon_timer_done), 32'h0);
    tick_n(1);
    chk("ibt_4000", 32'(invalid_beacon_timer_done), 32'h1);

    // beacon (20) and beacon_det (22)
    beacon_timer_start = 1'b1; beacon_det_timer_start = 1'b1;
    clk1();
    beacon_timer_start = 1'b0; beacon_det_timer_start = 1'b0;
    tick_n(19);
    chk("beacon_19", {29'h0, beacon_timer_done, beacon_det_timer_done,
                      beacon_det_timer_not_done}, 32'b001);
    tick_n(1);
    chk("beacon_20", 32'(beacon_timer_done), 32'h1);
    tick_n(1);
    chk("det_21", {30'h0, beacon_det_timer_done, beacon_det_timer_not_done}, 32'b01);
    tick_n(1);
    chk("det_22", {30'h0, beacon_det_timer_done, beacon_det_timer_not_done}, 32'b10);

    // all_timers_stop beats starts and clears everything
    all_timers_stop = 1'b1; beacon_timer_start = 1'b1; to_timer_start = 1'b1;
    clk1();
    all_timers_stop = 1'b0; beacon_timer_start = 1'b0; to_timer_start = 1'b0;
    chk("global_stop", 32'(outs()), 32'h0);
    tick_n(20);
    chk("global_stop_idle", 32'(outs()), 32'h0);

`ifdef PLCA_TIMER_DEBUG_EN
    to_timer_start = 1'b1;
    clk1();
    to_timer_start = 1'b0;
    chk("count_32", 32'(to_timer_count), 32'd32);
    for (int i = 1; i <= 32; i++) begin
      tick_n(1);
      chk("count_step", 32'(to_timer_count), 32'(32 - i));
    end
    chk("burst_count_idle", 32'(burst_timer_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
